// File: rtl/display_scheduler.sv
// Four-digit seven-segment scan scheduler: scan/frame timing, double-buffered digit store
// with frame-aligned commit, and per-digit enable generation (on/off, leading zero, blink).
module display_scheduler #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   input  logic [15:0] wr_data_i,
   input  logic [3:0]  wr_mask_i,
   input  logic        lz_en_i,
   input  logic [3:0]  blink_i,
   input  logic        display_on_i,
   output logic        scan_tick_o,
   output logic        frame_o,
   output logic        pending_o,
   output logic [3:0]  data_0_o,
   output logic [3:0]  data_1_o,
   output logic [3:0]  data_2_o,
   output logic [3:0]  data_3_o,
   output logic        en_0_o,
   output logic        en_1_o,
   output logic        en_2_o,
   output logic        en_3_o
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BlinkMax = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0] presc_q;
   logic [1:0]    ptr_q;
   logic [BW-1:0] blink_cnt_q;
   logic          phase_q;
   logic [15:0]   shadow_q, shadow_d;
   logic [15:0]   active_q, active_d;
   logic          pending_q, pending_d;
   logic          ready_q;
   logic [15:0]   data_q;
   logic [3:0]    en_q, en_d;
   logic [3:0]    lz;
   logic          tick, frame, accept;

   always_comb begin
      tick   = (presc_q == PrescMax);
      frame  = tick && (ptr_q == 2'd3);
      accept = wr_valid_i && ready_q;
   end

   // Accept needs ready, which implies no pending write, so accept and commit never coincide.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (frame && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         for (int k = 0; k < 4; k++) begin
            if (wr_mask_i[k]) shadow_d[4*k +: 4] = wr_data_i[4*k +: 4];
         end
         pending_d = 1'b1;
      end
   end

   // Blank a digit only while it and every digit to its left are zero; digit 3 always shows.
   always_comb begin
      lz[0] = lz_en_i && (active_q[3:0] == 4'd0);
      lz[1] = lz[0] && (active_q[7:4] == 4'd0);
      lz[2] = lz[1] && (active_q[11:8] == 4'd0);
      lz[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         en_d[k] = display_on_i && !lz[k] && !(blink_i[k] && phase_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q     <= '0;
         ptr_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         shadow_q    <= '0;
         active_q    <= '0;
         pending_q   <= 1'b0;
         ready_q     <= 1'b0;
         data_q      <= '0;
         en_q        <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         if (tick) ptr_q <= ptr_q + 1'b1;
         if (frame) begin
            if (blink_cnt_q == BlinkMax) begin
               blink_cnt_q <= '0;
               phase_q     <= !phase_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 1'b1;
            end
         end
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         ready_q   <= !pending_d;
         data_q    <= active_q;
         en_q      <= en_d;
      end
   end

   assign wr_ready_o  = ready_q;
   assign scan_tick_o = tick;
   assign frame_o     = frame;
   assign pending_o   = pending_q;
   assign data_0_o    = data_q[3:0];
   assign data_1_o    = data_q[7:4];
   assign data_2_o    = data_q[11:8];
   assign data_3_o    = data_q[15:12];
   assign en_0_o      = en_q[0];
   assign en_1_o      = en_q[1];
   assign en_2_o      = en_q[2];
   assign en_3_o      = en_q[3];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with SCAN_DIV=4 (frame every 16 cycles), BLINK_FRAMES=2.
module tb_display_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [15:0] wr_data = 16'h0;
   logic [3:0]  wr_mask = 4'h0;
   logic        lz_en = 1'b0;
   logic [3:0]  blink = 4'h0;
   logic        display_on = 1'b1;
   logic        scan_tick, frame, pending;
   logic [3:0]  d0, d1, d2, d3;
   logic        e0, e1, e2, e3;
   int          checks = 0;
   int          errors = 0;

   display_scheduler #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .wr_data_i(wr_data), .wr_mask_i(wr_mask), .lz_en_i(lz_en), .blink_i(blink),
      .display_on_i(display_on), .scan_tick_o(scan_tick), .frame_o(frame),
      .pending_o(pending), .data_0_o(d0), .data_1_o(d1), .data_2_o(d2), .data_3_o(d3),
      .en_0_o(e0), .en_1_o(e1), .en_2_o(e2), .en_3_o(e3)
   );

   always #5 clk = ~clk;

   // Returns at the falling edge inside a frame_o cycle.
   task automatic wait_frame();
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (frame) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wait_frame: frame_o not seen in 100 cycles, got 0 need 1");
      end
   endtask

   task automatic do_write(input logic [15:0] d, input logic [3:0] m);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_mask  = m;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_data  = 16'hDEAD;
      wr_mask  = 4'hF;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({wr_ready, scan_tick, frame, pending, d3, d2, d1, d0, e3, e2, e1, e0} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b tick=%b frame=%b pend=%b data=%h en=%b need all 0",
                  wr_ready, scan_tick, frame, pending, {d3, d2, d1, d0}, {e3, e2, e1, e0});
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (wr_ready !== 1'b1) begin
               errors++;
               $display("FAIL ready_rise: got %b need 1", wr_ready);
            end
            checks++;
            if ({d3, d2, d1, d0} !== 16'h0 || {e3, e2, e1, e0} !== 4'b1111) begin
               errors++;
               $display("FAIL first_outputs: got data=%h en=%b need 0000/1111",
                        {d3, d2, d1, d0}, {e3, e2, e1, e0});
            end
         end
         checks++;
         if (scan_tick !== ((c % 4) == 3) || frame !== (c == 15)) begin
            errors++;
            $display("FAIL scan_timing c=%0d: got tick=%b frame=%b need tick=%b frame=%b",
                     c, scan_tick, frame, (c % 4) == 3, c == 15);
         end
      end
   endtask

   task automatic test_full_write();
      do_write(16'h4321, 4'hF);
      @(negedge clk);
      checks++;
      if (pending !== 1'b1 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_pending: got pend=%b ready=%b need 1/0", pending, wr_ready);
      end
      wait_frame();
      checks++;
      if ({d3, d2, d1, d0} !== 16'h0) begin
         errors++;
         $display("FAIL no_tear: got data=%h need 0000", {d3, d2, d1, d0});
      end
      @(negedge clk);
      checks++;
      if (pending !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL commit_flags: got pend=%b ready=%b need 0/1", pending, wr_ready);
      end
      @(negedge clk);
      checks++;
      if ({d3, d2, d1, d0} !== 16'h4321) begin
         errors++;
         $display("FAIL full_write: got data=%h need 4321", {d3, d2, d1, d0});
      end
   endtask

   task automatic test_partial_write();
      do_write(16'hAAAA, 4'h4);
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({d3, d2, d1, d0} !== 16'h4A21) begin
         errors++;
         $display("FAIL partial_write: got data=%h need 4A21", {d3, d2, d1, d0});
      end
   endtask

   task automatic test_leading_zero();
      lz_en = 1'b1;
      do_write(16'h5400, 4'hF);
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({e3, e2, e1, e0} !== 4'b1100) begin
         errors++;
         $display("FAIL lz_0045: got en=%b need 1100", {e3, e2, e1, e0});
      end
      do_write(16'h0000, 4'hF);
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({e3, e2, e1, e0} !== 4'b1000) begin
         errors++;
         $display("FAIL lz_zero: got en=%b need 1000", {e3, e2, e1, e0});
      end
      do_write(16'h0070, 4'hF);
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({e3, e2, e1, e0} !== 4'b1110) begin
         errors++;
         $display("FAIL lz_0700: got en=%b need 1110", {e3, e2, e1, e0});
      end
      // Mask 0 still handshakes and commits an unchanged shadow.
      do_write(16'hFFFF, 4'h0);
      @(negedge clk);
      checks++;
      if (pending !== 1'b1) begin
         errors++;
         $display("FAIL mask0_pending: got %b need 1", pending);
      end
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({d3, d2, d1, d0} !== 16'h0070 || pending !== 1'b0) begin
         errors++;
         $display("FAIL mask0_commit: got data=%h pend=%b need 0070/0", {d3, d2, d1, d0}, pending);
      end
      lz_en = 1'b0;
   endtask

   task automatic test_blink();
      @(negedge clk);
      rst_n = 1'b0;
      blink = 4'h2;
      @(negedge clk);
      rst_n = 1'b1;
      // Frames land at c=15,31,47,63: phase flips at edges 32 and 64, en_1 one edge later.
      for (int c = 1; c <= 66; c++) begin
         @(negedge clk);
         if (c == 32 || c == 33 || c == 64 || c == 65) begin
            checks++;
            if (e1 !== (c == 32 || c == 65)) begin
               errors++;
               $display("FAIL blink_en1 c=%0d: got %b need %b", c, e1, c == 32 || c == 65);
            end
         end
         if (c == 33) begin
            checks++;
            if ({e3, e2, e0} !== 3'b111) begin
               errors++;
               $display("FAIL blink_others: got en3,en2,en0=%b need 111", {e3, e2, e0});
            end
         end
      end
      blink = 4'h0;
      display_on = 1'b0;
      @(negedge clk);
      checks++;
      if ({e3, e2, e1, e0} !== 4'b0000) begin
         errors++;
         $display("FAIL display_off: got en=%b need 0000", {e3, e2, e1, e0});
      end
      display_on = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      wait_frame();
      wr_valid = 1'b1;
      wr_data  = 16'h9876;
      wr_mask  = 4'hF;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (pending !== 1'b1 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL coincide_pending: got pend=%b ready=%b need 1/0", pending, wr_ready);
      end
      @(negedge clk);
      checks++;
      if ({d3, d2, d1, d0} !== 16'h0) begin
         errors++;
         $display("FAIL coincide_deferred: got data=%h need 0000", {d3, d2, d1, d0});
      end
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({d3, d2, d1, d0} !== 16'h9876 || pending !== 1'b0) begin
         errors++;
         $display("FAIL coincide_commit: got data=%h pend=%b need 9876/0", {d3, d2, d1, d0}, pending);
      end
   endtask

   task automatic test_reset_midop();
      do_write(16'h1111, 4'hF);
      @(negedge clk);
      checks++;
      if (pending !== 1'b1) begin
         errors++;
         $display("FAIL midop_pending: got %b need 1", pending);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_ready, pending, d3, d2, d1, d0, e3, e2, e1, e0} !== '0) begin
         errors++;
         $display("FAIL async_reset: got ready=%b pend=%b data=%h en=%b need all 0",
                  wr_ready, pending, {d3, d2, d1, d0}, {e3, e2, e1, e0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_frame();
      repeat (2) @(negedge clk);
      checks++;
      if ({d3, d2, d1, d0} !== 16'h0 || pending !== 1'b0) begin
         errors++;
         $display("FAIL write_lost: got data=%h pend=%b need 0000/0", {d3, d2, d1, d0}, pending);
      end
   endtask

   initial begin
      test_reset();
      test_full_write();
      test_partial_write();
      test_leading_zero();
      test_blink();
      test_back_to_back();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
